// File: rtl/hadamard_butterfly_pipelined.sv
// Three-stage pipelined Hadamard butterfly on one complex amplitude pair.
// It computes y0 = (a0 + a1)/sqrt2 and y1 = (a0 - a1)/sqrt2.
// Stage 1 forms the sums and differences.
// Stage 2 scales them by the 1/sqrt2 constant.
// Stage 3 rounds half toward +inf and saturates to WIDTH bits.
// All stages share a single advance enable, so a stall freezes the whole pipe.
// That keeps the pipe from dropping or duplicating a pair.

`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif
`ifndef FRAC_WIDTH
`define FRAC_WIDTH 12
`endif

module hadamard_butterfly_pipelined #(
    parameter int WIDTH     = `TOTAL_WIDTH,
    parameter int FRAC      = `FRAC_WIDTH,
    parameter int INV_SQRT2 = int'(real'(2 ** FRAC) / 1.4142135623730951)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] a0r,
    input  logic signed [WIDTH-1:0] a0i,
    input  logic signed [WIDTH-1:0] a1r,
    input  logic signed [WIDTH-1:0] a1i,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] y0r,
    output logic signed [WIDTH-1:0] y0i,
    output logic signed [WIDTH-1:0] y1r,
    output logic signed [WIDTH-1:0] y1i,
    output logic                    sat_flag,
    input  logic                    sat_clear
);

    // Full-precision product width: (WIDTH+1)-bit signed sum times (FRAC+1)-bit constant.
    localparam int PW = WIDTH + FRAC + 2;

    // The constant is below 2^FRAC, so its top bit is always 0 and it can be treated as signed.
    localparam logic signed [FRAC:0]   K    = (FRAC+1)'(INV_SQRT2);
    localparam logic signed [PW-1:0]   RND  = {{(PW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [PW-1:0]   MAXP = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0]   MINP = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]       MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]       MINV = {1'b1, {(WIDTH-1){1'b0}}};

    logic                  adv;
    logic                  take;
    logic                  v1, v2, v3;
    logic signed [WIDTH:0] s_r, s_i, d_r, d_i;
    logic signed [PW-1:0]  p_sr, p_si, p_dr, p_di;
    logic [WIDTH:0]        rs_0r, rs_0i, rs_1r, rs_1i;
    logic                  sat_any;

    // The returned value is {clamped, value}.
    function automatic logic [WIDTH:0] round_sat(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] q;
        q = (p + RND) >>> FRAC;
        if (q > MAXP)
            round_sat = {1'b1, MAXV};
        else if (q < MINP)
            round_sat = {1'b1, MINV};
        else
            round_sat = {1'b0, q[WIDTH-1:0]};
    endfunction

    assign adv       = !v3 || out_ready;
    assign in_ready  = adv;
    assign take      = in_valid && adv;
    assign out_valid = v3;

    assign rs_0r = round_sat(p_sr);
    assign rs_0i = round_sat(p_si);
    assign rs_1r = round_sat(p_dr);
    assign rs_1i = round_sat(p_di);

    // Only a real pair being loaded into stage 3 may report saturation; bubbles are ignored.
    assign sat_any = adv && v2 && (rs_0r[WIDTH] || rs_0i[WIDTH] || rs_1r[WIDTH] || rs_1i[WIDTH]);

    // Stage 1: per-component sum and difference, one extra bit so it cannot overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            s_r <= '0;
            s_i <= '0;
            d_r <= '0;
            d_i <= '0;
        end else if (adv) begin
            v1  <= take;
            s_r <= (WIDTH+1)'(a0r) + (WIDTH+1)'(a1r);
            s_i <= (WIDTH+1)'(a0i) + (WIDTH+1)'(a1i);
            d_r <= (WIDTH+1)'(a0r) - (WIDTH+1)'(a1r);
            d_i <= (WIDTH+1)'(a0i) - (WIDTH+1)'(a1i);
        end
    end

    // Stage 2: scale by 1/sqrt2 at full precision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            p_sr <= '0;
            p_si <= '0;
            p_dr <= '0;
            p_di <= '0;
        end else if (adv) begin
            v2   <= v1;
            p_sr <= PW'(s_r) * PW'(K);
            p_si <= PW'(s_i) * PW'(K);
            p_dr <= PW'(d_r) * PW'(K);
            p_di <= PW'(d_i) * PW'(K);
        end
    end

    // Stage 3: rounded, saturated results held stable while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3  <= 1'b0;
            y0r <= '0;
            y0i <= '0;
            y1r <= '0;
            y1i <= '0;
        end else if (adv) begin
            v3  <= v2;
            y0r <= rs_0r[WIDTH-1:0];
            y0i <= rs_0i[WIDTH-1:0];
            y1r <= rs_1r[WIDTH-1:0];
            y1i <= rs_1i[WIDTH-1:0];
        end
    end

    // Sticky saturation flag; a new saturation wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_flag <= 1'b0;
        else if (sat_any)
            sat_flag <= 1'b1;
        else if (sat_clear)
            sat_flag <= 1'b0;
    end

endmodule

// File: tb/tb_hadamard_butterfly_pipelined.sv
// Scoreboard bench for the pipelined Hadamard butterfly (WIDTH=16, FRAC=12, 1/sqrt2 = 2896).
// Stimulus pushes expected pairs when the DUT accepts them, and a monitor pops them on output handshakes.
module tb_hadamard_butterfly_pipelined;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] a0r = '0, a0i = '0, a1r = '0, a1i = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] y0r, y0i, y1r, y1i;
    logic               sat_flag;
    logic               sat_clear = 1'b0;

    hadamard_butterfly_pipelined #(.WIDTH(16), .FRAC(12), .INV_SQRT2(2896)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a0r       (a0r),
        .a0i       (a0i),
        .a1r       (a1r),
        .a1i       (a1i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y0r       (y0r),
        .y0i       (y0i),
        .y1r       (y1r),
        .y1i       (y1i),
        .sat_flag  (sat_flag),
        .sat_clear (sat_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] r0, i0, r1, i1;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int   cur_run = 0, max_run = 0;
    bit   stall_seen = 0, thr_drop = 0;
    bit   hold_valid = 0;
    logic signed [15:0] h0r, h0i, h1r, h1i;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference scaling, used only for the throughput vectors.
    function automatic int hb(input int s);
        longint p;
        p = (longint'(s) * 2896 + 2048) >>> 12;
        if (p > 32767) return 32767;
        if (p < -32768) return -32768;
        return int'(p);
    endfunction

    // Monitor: scoreboard pop, handshake relation, and stall stability.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold_valid = 0;
            cur_run    = 0;
        end else begin
            chk("in_ready_rel", int'(in_ready), int'(!out_valid || out_ready));
            if (hold_valid)
                chk("stall_hold", int'(out_valid && y0r == h0r && y0i == h0i && y1r == h1r && y1i == h1i), 1);
            hold_valid = out_valid && !out_ready;
            h0r = y0r; h0i = y0i; h1r = y1r; h1i = y1i;
            if (!in_ready) stall_seen = 1;
            if (in_valid && !in_ready) thr_drop = 1;
            if (out_valid) cur_run++; else cur_run = 0;
            if (cur_run > max_run) max_run = cur_run;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("y0r", int'(y0r), int'(e.r0));
                    chk("y0i", int'(y0i), int'(e.i0));
                    chk("y1r", int'(y1r), int'(e.r1));
                    chk("y1i", int'(y1i), int'(e.i1));
                end
            end
        end
    end

    // Present a pair, hold it until accepted, and queue its expected result.
    task automatic send(input int x0r, input int x0i, input int x1r, input int x1i,
                        input int e0r, input int e0i, input int e1r, input int e1i);
        exp_t e;
        a0r = 16'(x0r); a0i = 16'(x0i); a1r = 16'(x1r); a1i = 16'(x1i);
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                e.r0 = 16'(e0r); e.i0 = 16'(e0i); e.r1 = 16'(e1r); e.i1 = 16'(e1i);
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                return;
            end
        end
        chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && exp_q.size() > 0; k++) @(negedge clk);
        chk("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int bp_exp[5];
        int lat;
        bp_exp = '{141, 283, 424, 566, 707};

        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_y0r", int'(y0r), 0);
        chk("rst_sat", int'(sat_flag), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basis state, latency and single-cycle output.
        send(4096, 0, 0, 0, 2896, 0, 2896, 0);
        in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (out_valid) begin lat = k; break; end
        end
        chk("basis_latency", lat, 3);
        @(negedge clk);
        chk("basis_one_cycle", int'(out_valid), 0);
        chk("basis_sat", int'(sat_flag), 0);
        @(posedge clk); #1;

        // Equal amplitudes.
        send(4096, -4096, 4096, -4096, 5792, -5792, 0, 0);
        in_valid = 1'b0;
        drain();

        // Saturation at both rails, then the sticky flag and its clear.
        send(32767, 0, 32767, 0, 32767, 0, 0, 0);
        send(-32768, 0, -32768, 0, -32768, 0, 0, 0);
        in_valid = 1'b0;
        drain();
        chk("sat_set", int'(sat_flag), 1);
        sat_clear = 1'b1;
        @(posedge clk); #1;
        sat_clear = 1'b0;
        chk("sat_cleared", int'(sat_flag), 0);

        // A clear coinciding with a new saturating load leaves the flag set.
        send(32767, 100, 32767, 100, 32767, 141, 0, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        sat_clear = 1'b1;
        @(posedge clk); #1;
        sat_clear = 1'b0;
        chk("sat_set_wins", int'(sat_flag), 1);
        drain();
        sat_clear = 1'b1;
        @(posedge clk); #1;
        sat_clear = 1'b0;
        chk("sat_cleared2", int'(sat_flag), 0);

        // Back-pressure: five pairs streamed while the consumer stalls.
        stall_seen = 0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(100 * (i + 1), 0, 100 * (i + 1), 0, bp_exp[i], 0, 0, 0);
                in_valid = 1'b0;
            end
            begin
                @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_in_ready_dropped", int'(stall_seen), 1);

        // Full throughput: sixteen back-to-back pairs.
        thr_drop = 0;
        max_run  = 0;
        for (int i = 0; i < 16; i++) begin
            int x0r, x0i, x1r, x1i;
            x0r = i * 256 - 2048; x0i = i * 100; x1r = 1000 - i * 64; x1i = -i * 50;
            send(x0r, x0i, x1r, x1i, hb(x0r + x1r), hb(x0i + x1i), hb(x0r - x1r), hb(x0i - x1i));
        end
        in_valid = 1'b0;
        drain();
        chk("thr_no_stall", int'(thr_drop), 0);
        chk("thr_run", max_run, 16);

        // Reset with two pairs in flight.
        send(4096, 0, 0, 0, 2896, 0, 2896, 0);
        send(0, 4096, 0, 0, 0, 2896, 0, 2896);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_y", int'(y0r == 0 && y0i == 0 && y1r == 0 && y1i == 0), 1);
        chk("midrst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send(-4096, 0, 4096, 0, 0, 0, -5792, 0);
        in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (out_valid) begin lat = k; break; end
        end
        chk("post_rst_latency", lat, 3);
        @(posedge clk); #1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
